// File: rtl/y86_pkg.sv
// Shared Y86 execute/memory pipeline definitions: status codes, the X->M entry type and its bubble form.
package y86_pkg;

    localparam logic [3:0] STAT_AOK  = 4'h1;
    localparam logic [3:0] STAT_HLT  = 4'h2;
    localparam logic [3:0] STAT_ADR  = 4'h3;
    localparam logic [3:0] STAT_INS  = 4'h4;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;

    localparam int unsigned VAL_W_MAX = 64;
    localparam int unsigned HDR_W     = 21;

    typedef struct packed {
        logic [3:0]           stat;
        logic [3:0]           icode;
        logic [3:0]           ifun;
        logic [3:0]           destE;
        logic [3:0]           destM;
        logic                 cnd;
        logic [VAL_W_MAX-1:0] valA;
        logic [VAL_W_MAX-1:0] valE;
    } xm_entry_t;

    // NOP that writes no register and carries no data.
    function automatic xm_entry_t bubble_entry();
        xm_entry_t e;
        e       = '0;
        e.stat  = STAT_AOK;
        e.icode = ICODE_NOP;
        e.destE = REG_NONE;
        e.destM = REG_NONE;
        return e;
    endfunction

endpackage

// File: rtl/pipe_fifo.sv
// Circular entry storage with wrapping write/read pointers; occupancy is tracked by the caller.
module pipe_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned EW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [EW-1:0] i_wdata,
    output logic [EW-1:0] o_rdata
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    // Wrap from DEPTH-1 to 0 so non power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];

endmodule

// File: rtl/xm_pipe_buf.sv
// Execute-to-memory pipeline buffer with bubble injection, halt-on-fault and flush.
// Optional event counters (bubble_cnt, stall_cnt) are built when XM_PIPE_BUF_CNT_EN is defined.
module xm_pipe_buf
    import y86_pkg::*;
#(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       bubble,
    input  logic                       flush,
    input  logic [3:0]                 e_stat,
    input  logic [3:0]                 e_icode,
    input  logic [3:0]                 e_ifun,
    input  logic [3:0]                 e_destE,
    input  logic [3:0]                 e_destM,
    input  logic                       e_cnd,
    input  logic [W-1:0]               e_valA,
    input  logic [W-1:0]               e_valE,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 M_stat,
    output logic [3:0]                 M_icode,
    output logic [3:0]                 M_ifun,
    output logic [3:0]                 M_destE,
    output logic [3:0]                 M_destM,
    output logic                       M_cnd,
    output logic [W-1:0]               M_valA,
    output logic [W-1:0]               M_valE,
`ifdef XM_PIPE_BUF_CNT_EN
    output logic [31:0]                bubble_cnt,
    output logic [31:0]                stall_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       halted
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = HDR_W + 2 * W;

    xm_entry_t     w_bub;
    logic [EW-1:0] w_bub_flat;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_rdata;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] r_count;
    logic          r_halted;

    assign w_bub      = bubble_entry();
    assign w_bub_flat = {w_bub.stat, w_bub.icode, w_bub.ifun, w_bub.destE, w_bub.destM,
                         w_bub.cnd, W'(w_bub.valA), W'(w_bub.valE)};

    // A bubble consumes and drops whatever payload is on the execute side.
    always_comb begin
        w_wdata = {e_stat, e_icode, e_ifun, e_destE, e_destM, e_cnd, e_valA, e_valE};
        if (bubble) w_wdata = w_bub_flat;
    end

    assign in_ready  = (r_count < CW'(DEPTH)) && !r_halted;
    assign out_valid = (r_count != '0);
    assign w_push    = (in_valid || bubble) && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_halted <= 1'b0;
        end else if (flush) begin
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            if (w_push && (w_wdata[EW-1 -: 4] != STAT_AOK)) r_halted <= 1'b1;
        end
    end

    pipe_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Head entry straight from storage; bubble form whenever nothing is buffered.
    assign {M_stat, M_icode, M_ifun, M_destE, M_destM, M_cnd, M_valA, M_valE} =
        out_valid ? w_rdata : w_bub_flat;

    assign count  = r_count;
    assign halted = r_halted;

`ifdef XM_PIPE_BUF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_push && bubble && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (in_valid && !in_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_xm_pipe_buf.sv
// Directed bench for xm_pipe_buf: DEPTH=2 and DEPTH=3 instances share one stimulus stream.
module tb_xm_pipe_buf;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, bubble, flush, out_ready;
    logic [3:0]   e_stat, e_icode, e_ifun, e_destE, e_destM;
    logic         e_cnd;
    logic [W-1:0] e_valA, e_valE;

    logic         in_ready2, out_valid2, M_cnd2, halted2;
    logic [3:0]   M_stat2, M_icode2, M_ifun2, M_destE2, M_destM2;
    logic [W-1:0] M_valA2, M_valE2;
    logic [1:0]   count2;

    logic         in_ready3, out_valid3, M_cnd3, halted3;
    logic [3:0]   M_stat3, M_icode3, M_ifun3, M_destE3, M_destM3;
    logic [W-1:0] M_valA3, M_valE3;
    logic [1:0]   count3;

`ifdef XM_PIPE_BUF_CNT_EN
    logic [31:0]  bubble_cnt2, stall_cnt2, bubble_cnt3, stall_cnt3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    xm_pipe_buf #(.W(W), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .bubble(bubble), .flush(flush),
        .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun), .e_destE(e_destE),
        .e_destM(e_destM), .e_cnd(e_cnd), .e_valA(e_valA), .e_valE(e_valE),
        .out_valid(out_valid2), .out_ready(out_ready),
        .M_stat(M_stat2), .M_icode(M_icode2), .M_ifun(M_ifun2), .M_destE(M_destE2),
        .M_destM(M_destM2), .M_cnd(M_cnd2), .M_valA(M_valA2), .M_valE(M_valE2),
`ifdef XM_PIPE_BUF_CNT_EN
        .bubble_cnt(bubble_cnt2), .stall_cnt(stall_cnt2),
`endif
        .count(count2), .halted(halted2)
    );

    xm_pipe_buf #(.W(W), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .bubble(bubble), .flush(flush),
        .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun), .e_destE(e_destE),
        .e_destM(e_destM), .e_cnd(e_cnd), .e_valA(e_valA), .e_valE(e_valE),
        .out_valid(out_valid3), .out_ready(out_ready),
        .M_stat(M_stat3), .M_icode(M_icode3), .M_ifun(M_ifun3), .M_destE(M_destE3),
        .M_destM(M_destM3), .M_cnd(M_cnd3), .M_valA(M_valA3), .M_valE(M_valE3),
`ifdef XM_PIPE_BUF_CNT_EN
        .bubble_cnt(bubble_cnt3), .stall_cnt(stall_cnt3),
`endif
        .count(count3), .halted(halted3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic [3:0] stat, input logic [3:0] icode,
                             input logic [W-1:0] vale);
        e_stat  = stat;
        e_icode = icode;
        e_valE  = vale;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; bubble = 1'b0; flush = 1'b0; out_ready = 1'b0;
        e_stat = 4'h1; e_icode = 4'h0; e_ifun = 4'h0; e_destE = 4'h2; e_destM = 4'h3;
        e_cnd = 1'b0; e_valA = '0; e_valE = '0;

        // Reset state
        #12;
        check("rst_count", 64'(count2), 64'd0);
        check("rst_out_valid", 64'(out_valid2), 64'd0);
        check("rst_M_icode", 64'(M_icode2), 64'h1);
        check("rst_M_destE", 64'(M_destE2), 64'hF);
        check("rst_halted", 64'(halted2), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready2), 64'd1);

        // Fill DEPTH=2 with out_ready low, then drain in order
        step();
        in_valid = 1'b1;
        set_entry(4'h1, 4'h6, 64'h10);
        step();
        check("a_first_vis", 64'(M_icode2), 64'h6);
        check("a_count1", 64'(count2), 64'd1);
        set_entry(4'h1, 4'h3, 64'h20);
        step();
        in_valid = 1'b0;
        check("a_count2", 64'(count2), 64'd2);
        check("a_full_ready", 64'(in_ready2), 64'd0);
        check("a_head_icode", 64'(M_icode2), 64'h6);
        check("a_head_valE", M_valE2, 64'h10);
        step();
        check("a_stable_icode", 64'(M_icode2), 64'h6);
        check("a_stable_valid", 64'(out_valid2), 64'd1);
        out_ready = 1'b1;
        step();
        check("a_pop1_icode", 64'(M_icode2), 64'h3);
        check("a_pop1_valE", M_valE2, 64'h20);
        check("a_pop1_count", 64'(count2), 64'd1);
        step();
        check("a_empty_count", 64'(count2), 64'd0);
        check("a_empty_valid", 64'(out_valid2), 64'd0);
        check("a_empty_icode", 64'(M_icode2), 64'h1);
        out_ready = 1'b0;

        // Bubble overrides a concurrent valid payload
        bubble = 1'b1; in_valid = 1'b1;
        set_entry(4'h1, 4'h7, 64'h55);
        e_cnd = 1'b1; e_valA = 64'h5;
        step();
        bubble = 1'b0; in_valid = 1'b0; e_cnd = 1'b0; e_valA = '0;
        check("b_count", 64'(count2), 64'd1);
        check("b_icode", 64'(M_icode2), 64'h1);
        check("b_destE", 64'(M_destE2), 64'hF);
        check("b_destM", 64'(M_destM2), 64'hF);
        check("b_stat", 64'(M_stat2), 64'h1);
        check("b_cnd", 64'(M_cnd2), 64'd0);
        check("b_valE", M_valE2, 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("b_flush_count", 64'(count2), 64'd0);

        // DEPTH=3 streaming with continuous out_ready: pointers wrap, count stays at 1
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            set_entry(4'h1, 4'(i), 64'(100 + i));
            step();
            check($sformatf("c_icode%0d", i), 64'(M_icode3), 64'(i));
            check($sformatf("c_valE%0d", i), M_valE3, 64'(100 + i));
            check($sformatf("c_count%0d", i), 64'(count3), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check("c_drained", 64'(count3), 64'd0);
        out_ready = 1'b0;

        // HLT entry halts intake; flush clears it
        in_valid = 1'b1;
        set_entry(4'h2, 4'h0, 64'h0);
        step();
        set_entry(4'h1, 4'h5, 64'h0);
        check("d_halted", 64'(halted2), 64'd1);
        check("d_in_ready", 64'(in_ready2), 64'd0);
        step();
        in_valid = 1'b0;
        check("d_refused_count", 64'(count2), 64'd1);
        check("d_head_stat", 64'(M_stat2), 64'h2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("d_flush_count", 64'(count2), 64'd0);
        check("d_flush_halted", 64'(halted2), 64'd0);
        check("d_flush_ready", 64'(in_ready2), 64'd1);

        // Asynchronous reset mid-cycle with two entries buffered
        in_valid = 1'b1;
        set_entry(4'h1, 4'h6, 64'h1);
        step();
        step();
        in_valid = 1'b0;
        check("e_pre_count", 64'(count2), 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("e_async_valid", 64'(out_valid2), 64'd0);
        check("e_async_icode", 64'(M_icode2), 64'h1);
        check("e_async_count", 64'(count2), 64'd0);
        rst_n = 1'b1;
        step();

`ifdef XM_PIPE_BUF_CNT_EN
        // Three bubble pushes, then four stalled cycles on a full buffer
        out_ready = 1'b1;
        bubble = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bubble = 1'b0;
        step();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_entry(4'h1, 4'h2, 64'h0);
        for (int i = 0; i < 6; i++) step();
        in_valid = 1'b0;
        check("f_full_count", 64'(count2), 64'd2);
        check("f_bubble_cnt", 64'(bubble_cnt2), 64'd3);
        check("f_stall_cnt", 64'(stall_cnt2), 64'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("f_flush_bubble_cnt", 64'(bubble_cnt2), 64'd3);
        check("f_flush_stall_cnt", 64'(stall_cnt2), 64'd4);
        check("f_flush_count", 64'(count2), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xm_pipe_buf.md
XM_PIPE_BUF -- requirements
Module: xm_pipe_buf

Interface
REQ-001 SHALL have parameter W, default 64, width of valA/valE.
REQ-002 SHALL have parameter DEPTH, default 2, entry count, legal range 1..8, not required to be a power of two.
REQ-003 SHALL have clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have in_valid  in  1, and in_ready  out  1, for the execute-side handshake.
REQ-006 SHALL have bubble  in  1, replaces the pushed payload with the bubble form.
REQ-007 SHALL have flush  in  1, synchronous empty plus halt clear.
REQ-008 SHALL have e_stat, e_icode, e_ifun, e_destE, e_destM  in  4 each; e_cnd  in  1; e_valA, e_valE  in  W.
REQ-009 SHALL have out_valid  out  1, and out_ready  in  1, for the memory-side handshake.
REQ-010 SHALL have M_stat, M_icode, M_ifun, M_destE, M_destM  out  4 each; M_cnd  out  1; M_valA, M_valE  out  W.
REQ-011 SHALL have count  out  $clog2(DEPTH+1), current occupancy.
REQ-012 SHALL have halted  out  1, set when a non-AOK entry has been accepted.

Function
REQ-013 SHALL store entries {stat,icode,ifun,destE,destM,cnd,valA,valE} in a circular buffer of DEPTH entries.
REQ-014 SHALL use a write pointer and a read pointer that wrap from DEPTH-1 to 0.
REQ-015 SHALL drive in_ready = (count<DEPTH) && !halted, from registered state only; no combinational path from out_ready.
REQ-016 SHALL push when (in_valid || bubble) && in_ready.
REQ-017 SHALL push the bubble form when bubble=1: icode=1 (NOP), ifun=0, destE=destM=4'hF, stat=AOK(1), cnd=0, valA=valE=0; any concurrent input payload is consumed and dropped.
REQ-018 SHALL pop when out_valid && out_ready, with out_valid = (count!=0).
REQ-019 SHALL present the head entry on M_* combinationally from storage, giving one cycle of latency from push to visibility.
REQ-020 SHALL drive the bubble form on M_* while empty.
REQ-021 SHALL leave count unchanged on a simultaneous push and pop; when full, a push is blocked by in_ready=0 even if a pop occurs in the same cycle.
REQ-022 SHALL set halted on the cycle after a pushed entry has stat!=AOK, and hold in_ready=0 thereafter.
REQ-023 SHALL keep popping while halted, so that already-buffered entries drain.
REQ-024 SHALL, on flush=1, zero count and both pointers and clear halted; flush takes priority over a same-cycle push or pop, and neither occurs.
REQ-025 SHALL keep M_* stable while out_valid=1 and out_ready=0.

Reset
REQ-026 SHALL, on rst_n low, asynchronously set count=0, both pointers=0, halted=0, out_valid=0, and M_* to the bubble form.
REQ-027 SHALL discard all buffered entries on reset asserted mid-operation; storage contents need not be cleared.
REQ-028 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with XM_PIPE_BUF_CNT_EN defined, add outputs bubble_cnt (32) and stall_cnt (32).
REQ-030 SHALL increment bubble_cnt on each bubble push and stall_cnt on each cycle with in_valid && !in_ready; both saturate at 2^32-1 and are cleared by reset only, not by flush.
REQ-031 SHALL, without XM_PIPE_BUF_CNT_EN, have neither these ports nor their logic.

Structure
REQ-032 SHALL place stat codes (AOK=1, HLT=2, ADR=3, INS=4), ICODE_NOP=4'h1, REG_NONE=4'hF, typedef xm_entry_t and function bubble_entry() in shared package y86_pkg.
REQ-033 SHALL implement storage and pointer wrap in one sub-module pipe_fifo, parametrised by DEPTH and entry width; handshake, bubble, halt and counter logic stay in xm_pipe_buf.

Verification
REQ-034 SHALL cover: DEPTH=2; push icode=6 valE=0x10, then icode=3 valE=0x20, out_ready=0 -> count=2, in_ready=0, M_icode=6; raise out_ready -> 6 then 3 over two cycles.
REQ-035 SHALL cover: bubble=1 with in_valid=1 and icode=7 -> pushed entry M_icode=1, M_destE=M_destM=F, M_stat=1, M_cnd=0.
REQ-036 SHALL cover: DEPTH=3; 10 pushes with out_ready=1 continuous -> in-order output and pointer wrap, count never exceeds 1.
REQ-037 SHALL cover: push stat=2 (HLT) then stat=1 -> halted=1 next cycle, in_ready=0, second entry refused; flush -> count=0, halted=0, in_ready=1.
REQ-038 SHALL cover: count=2, assert rst_n=0 mid-cycle -> out_valid=0 and M_icode=1 immediately, without waiting for a clock edge.
REQ-039 SHALL cover, with XM_PIPE_BUF_CNT_EN: 3 bubble pushes and 4 stalled cycles -> bubble_cnt=3, stall_cnt=4; a flush leaves both unchanged.
